// File: rtl/pixel_dispatch.sv
// pixel_dispatch
//
// Walks a frame in raster order and issues one pixel request per cycle
// ({x, y, linear address}) to the render pipeline. Issue is throttled by
// two windows:
//   - outstanding: requests issued but not yet returned (credit window, max N)
//   - lines_pending: fully issued lines not yet consumed downstream
//     (max LINES_AHEAD)
//
// State table
//   state       | meaning
//   ------------+--------------------------------------------------------
//   S_IDLE      | waiting for frame_start
//   S_RUN       | issuing pixels, limited by the credit window
//   S_WAIT_LINE | line window full, waiting for line_done
//   S_DRAIN     | all pixels issued, waiting for credits and lines to retire
//
// Ports
//   PPL_clk      in   single clock
//   rst_n        in   synchronous active-low reset
//   frame_start  in   one-cycle pulse, starts a frame from IDLE
//   pix_ready    in   pipeline accepts the current request
//   pix_valid    out  request valid (held with payload until accepted)
//   pix_x        out  pixel column
//   pix_y        out  pixel row
//   pix_addr     out  linear address y*H_DISP + x
//   ret_valid    in   one pixel result returned; frees one credit
//   line_done    in   downstream consumed one line
//   busy         out  state is not IDLE
//   frame_done   out  one-cycle pulse at end of frame
//   err          out  sticky protocol error (cleared only by reset)

module pixel_dispatch #(
    parameter int H_DISP      = 1280,
    parameter int V_DISP      = 720,
    parameter int N           = 16,
    parameter int LINES_AHEAD = 1
) (
    input  logic                      PPL_clk,
    input  logic                      rst_n,
    input  logic                      frame_start,
    input  logic                      pix_ready,
    output logic                      pix_valid,
    output logic [$clog2(H_DISP)-1:0] pix_x,
    output logic [$clog2(V_DISP)-1:0] pix_y,
    output logic [19:0]               pix_addr,
    input  logic                      ret_valid,
    input  logic                      line_done,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      err
);

    localparam int XW = $clog2(H_DISP);
    localparam int YW = $clog2(V_DISP);
    localparam int OW = $clog2(N + 1);
    localparam int LW = $clog2(LINES_AHEAD + 1);

    localparam logic [XW-1:0] X_LAST = XW'(H_DISP - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_DISP - 1);
    localparam logic [OW-1:0] N_CNT  = OW'(N);
    localparam logic [LW-1:0] L_MAX  = LW'(LINES_AHEAD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_WAIT_LINE,
        S_DRAIN
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [OW-1:0]  outstanding;
    logic [OW-1:0]  out_nxt;
    logic [LW-1:0]  lines_pending;
    logic [LW-1:0]  lines_nxt;

    logic [XW-1:0]  x_nxt;
    logic [YW-1:0]  y_nxt;
    logic [19:0]    addr_nxt;
    logic           valid_nxt;
    logic           busy_nxt;
    logic           done_nxt;
    logic           err_nxt;

    logic           xfer;
    logic           ret_ok;
    logic           ld_ok;
    logic           line_end;
    logic           frame_end;

    always_comb begin
        xfer      = pix_valid & pix_ready;
        // Returns that would underflow a counter are dropped and flagged.
        ret_ok    = ret_valid & (outstanding != '0);
        ld_ok     = line_done & (lines_pending != '0);
        line_end  = xfer & (pix_x == X_LAST);
        frame_end = line_end & (pix_y == Y_LAST);

        out_nxt = outstanding;
        if (xfer && !ret_ok) begin
            out_nxt = outstanding + 1'b1;
        end else if (!xfer && ret_ok) begin
            out_nxt = outstanding - 1'b1;
        end

        lines_nxt = lines_pending;
        if (line_end && !ld_ok) begin
            lines_nxt = lines_pending + 1'b1;
        end else if (!line_end && ld_ok) begin
            lines_nxt = lines_pending - 1'b1;
        end

        state_nxt = state;
        x_nxt     = pix_x;
        y_nxt     = pix_y;
        addr_nxt  = pix_addr;

        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    state_nxt = S_RUN;
                    out_nxt   = '0;
                    lines_nxt = '0;
                    x_nxt     = '0;
                    y_nxt     = '0;
                    addr_nxt  = '0;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    x_nxt    = pix_x + 1'b1;
                    addr_nxt = pix_addr + 20'd1;
                    if (frame_end) begin
                        // Park the payload at the origin; the next frame
                        // reloads it anyway.
                        state_nxt = S_DRAIN;
                        x_nxt     = '0;
                        y_nxt     = '0;
                        addr_nxt  = '0;
                    end else if (line_end) begin
                        x_nxt = '0;
                        y_nxt = pix_y + 1'b1;
                        if (lines_nxt == L_MAX) begin
                            state_nxt = S_WAIT_LINE;
                        end
                    end
                end
            end
            S_WAIT_LINE: begin
                if (lines_nxt < L_MAX) begin
                    state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                if ((out_nxt == '0) && (lines_nxt == '0)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Looking at next-cycle credits lets a same-cycle return keep the
        // request stream going. While a request waits for pix_ready the
        // credit count can only fall, so valid never drops before acceptance.
        valid_nxt = (state_nxt == S_RUN) && (out_nxt < N_CNT);
        busy_nxt  = (state_nxt != S_IDLE);
        done_nxt  = (state == S_DRAIN) && (state_nxt == S_IDLE);
        err_nxt   = err | (ret_valid & ~ret_ok) | (line_done & ~ld_ok);
    end

    always_ff @(posedge PPL_clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            outstanding   <= '0;
            lines_pending <= '0;
            pix_valid     <= 1'b0;
            pix_x         <= '0;
            pix_y         <= '0;
            pix_addr      <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_nxt;
            outstanding   <= out_nxt;
            lines_pending <= lines_nxt;
            pix_valid     <= valid_nxt;
            pix_x         <= x_nxt;
            pix_y         <= y_nxt;
            pix_addr      <= addr_nxt;
            busy          <= busy_nxt;
            frame_done    <= done_nxt;
            err           <= err_nxt;
        end
    end

endmodule

// File: tb/tb_pixel_dispatch.sv
// Testbench for pixel_dispatch with an 8x4 frame, 4 credits and a one-line
// window. Expected payloads are queued per frame and popped as the DUT
// transfers them; scenario tasks check timing-specific behaviour inline.

module tb_pixel_dispatch;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int NN = 4;
    localparam int LA = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        pix_ready;
    logic        ret_valid;
    logic        line_done;
    logic        pix_valid;
    logic [2:0]  pix_x;
    logic [1:0]  pix_y;
    logic [19:0] pix_addr;
    logic        busy;
    logic        frame_done;
    logic        err;

    always #5 clk = ~clk;

    pixel_dispatch #(
        .H_DISP      (H),
        .V_DISP      (V),
        .N           (NN),
        .LINES_AHEAD (LA)
    ) dut (
        .PPL_clk     (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_ready   (pix_ready),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_addr    (pix_addr),
        .ret_valid   (ret_valid),
        .line_done   (line_done),
        .busy        (busy),
        .frame_done  (frame_done),
        .err         (err)
    );

    int          total = 0;
    int          bad   = 0;
    logic [24:0] exp_q[$];
    int          n_xfer  = 0;
    int          m_out   = 0;
    int          m_lines = 0;

    logic        hold_prev = 1'b0;
    logic [24:0] prev_pay;
    logic [24:0] mon_exp;
    logic        mon_xf;
    logic        mon_rt;
    logic        mon_ld;

    // Scoreboard and hold monitor. Inputs are stable at the falling edge, so
    // what is seen here is what the next rising edge acts on.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_out     = 0;
            m_lines   = 0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                total++;
                if (pix_valid !== 1'b1 || {pix_x, pix_y, pix_addr} !== prev_pay) begin
                    bad++;
                    $display("FAIL hold_stable: got valid=%b pay=%h want valid=1 pay=%h",
                             pix_valid, {pix_x, pix_y, pix_addr}, prev_pay);
                end
            end
            hold_prev = pix_valid && !pix_ready;
            prev_pay  = {pix_x, pix_y, pix_addr};

            mon_xf = pix_valid && pix_ready;
            mon_rt = ret_valid && (m_out > 0);
            mon_ld = line_done && (m_lines > 0);
            if (mon_xf) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL xfer_unexpected: got pay=%h want no transfer",
                             {pix_x, pix_y, pix_addr});
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({pix_x, pix_y, pix_addr} !== mon_exp) begin
                        bad++;
                        $display("FAIL xfer_payload: got pay=%h want %h",
                                 {pix_x, pix_y, pix_addr}, mon_exp);
                    end
                    if (mon_exp[24:22] == 3'(H - 1)) m_lines++;
                end
                n_xfer++;
                m_out++;
            end
            if (mon_rt) m_out--;
            if (mon_ld) m_lines--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                exp_q.push_back({3'(x), 2'(y), 20'(y * H + x)});
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            frame_start = 1'($urandom_range(0, 1));
            pix_ready   = 1'($urandom_range(0, 1));
            ret_valid   = 1'($urandom_range(0, 1));
            line_done   = 1'($urandom_range(0, 1));
            tick();
            total++;
            if ({pix_valid, pix_x, pix_y, pix_addr, busy, frame_done, err} !== 30'd0) begin
                bad++;
                $display("FAIL reset_outputs: got %h want 0",
                         {pix_valid, pix_x, pix_y, pix_addr, busy, frame_done, err});
            end
        end
        frame_start = 1'b0;
        pix_ready   = 1'b0;
        ret_valid   = 1'b0;
        line_done   = 1'b0;
        rst_n       = 1'b1;
        tick();
        total++;
        if ({pix_valid, busy, frame_done, err} !== 4'b0000) begin
            bad++;
            $display("FAIL idle_outputs: got %b want 0000", {pix_valid, busy, frame_done, err});
        end
        n_xfer = 0;
        push_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        total++;
        if ({pix_valid, busy, pix_x, pix_y, pix_addr} !== {2'b11, 25'd0}) begin
            bad++;
            $display("FAIL start_first: got valid=%b busy=%b x=%0d y=%0d addr=%0d want 1 1 0 0 0",
                     pix_valid, busy, pix_x, pix_y, pix_addr);
        end
    endtask

    task automatic test_credit_limit();
        pix_ready = 1'b1;
        repeat (4) tick();
        total++;
        if (n_xfer !== 4 || pix_valid !== 1'b0) begin
            bad++;
            $display("FAIL credit_stop: got xfers=%0d valid=%b want 4 0", n_xfer, pix_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (pix_valid !== 1'b0) begin
                bad++;
                $display("FAIL credit_hold_low: got valid=%b want 0", pix_valid);
            end
        end
        ret_valid = 1'b1;
        tick();
        ret_valid = 1'b0;
        total++;
        if (pix_valid !== 1'b1 || pix_addr !== 20'd4 || pix_x !== 3'd4 || pix_y !== 2'd0) begin
            bad++;
            $display("FAIL credit_return: got valid=%b addr=%0d x=%0d y=%0d want 1 4 4 0",
                     pix_valid, pix_addr, pix_x, pix_y);
        end
        tick();
        total++;
        if (n_xfer !== 5 || pix_valid !== 1'b0) begin
            bad++;
            $display("FAIL credit_one_more: got xfers=%0d valid=%b want 5 0", n_xfer, pix_valid);
        end
    endtask

    task automatic test_line_window();
        pix_ready = 1'b1;
        for (int i = 0; i < 40 && n_xfer < 8; i++) begin
            ret_valid = (m_out > 0);
            tick();
        end
        ret_valid = 1'b0;
        total++;
        if (n_xfer !== 8 || pix_valid !== 1'b0) begin
            bad++;
            $display("FAIL line_window_stop: got xfers=%0d valid=%b want 8 0", n_xfer, pix_valid);
        end
        for (int i = 0; i < 20 && m_out > 0; i++) begin
            ret_valid = 1'b1;
            tick();
        end
        ret_valid = 1'b0;
        tick();
        total++;
        if (pix_valid !== 1'b0) begin
            bad++;
            $display("FAIL line_window_hold: got valid=%b want 0", pix_valid);
        end
        line_done = 1'b1;
        tick();
        line_done = 1'b0;
        total++;
        if (pix_valid !== 1'b1 || pix_x !== 3'd0 || pix_y !== 2'd1 || pix_addr !== 20'd8) begin
            bad++;
            $display("FAIL line_resume: got valid=%b x=%0d y=%0d addr=%0d want 1 0 1 8",
                     pix_valid, pix_x, pix_y, pix_addr);
        end
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        while (n_xfer < 32 && cyc < 2000) begin
            pix_ready   = 1'($urandom_range(0, 1));
            ret_valid   = (m_out > 0) && ($urandom_range(0, 3) != 0);
            line_done   = (m_lines > 0) && ($urandom_range(0, 3) == 0);
            frame_start = (cyc == 10);
            tick();
            cyc++;
        end
        pix_ready   = 1'b0;
        ret_valid   = 1'b0;
        line_done   = 1'b0;
        frame_start = 1'b0;
        total++;
        if (n_xfer !== 32) begin
            bad++;
            $display("FAIL bp_complete: got xfers=%0d want 32", n_xfer);
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL bp_queue_empty: got %0d left want 0", exp_q.size());
        end
        total++;
        if ({pix_valid, busy, err} !== 3'b010) begin
            bad++;
            $display("FAIL bp_drain_state: got valid=%b busy=%b err=%b want 0 1 0",
                     pix_valid, busy, err);
        end
    endtask

    task automatic test_frame_end();
        int pulses = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            ret_valid = (m_out > 0);
            line_done = (m_lines > 0);
            tick();
            if (frame_done === 1'b1) begin
                pulses++;
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL done_busy: got busy=%b want 0", busy);
                end
            end
        end
        ret_valid = 1'b0;
        line_done = 1'b0;
        total++;
        if (pulses !== 1) begin
            bad++;
            $display("FAIL done_pulses: got %0d want 1", pulses);
        end
        total++;
        if ({pix_valid, busy, frame_done, err} !== 4'b0000) begin
            bad++;
            $display("FAIL after_done: got %b want 0000", {pix_valid, busy, frame_done, err});
        end
        n_xfer = 0;
        push_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        total++;
        if ({pix_valid, busy, pix_x, pix_y, pix_addr} !== {2'b11, 25'd0}) begin
            bad++;
            $display("FAIL restart: got valid=%b busy=%b x=%0d y=%0d addr=%0d want 1 1 0 0 0",
                     pix_valid, busy, pix_x, pix_y, pix_addr);
        end
    endtask

    task automatic test_errors();
        ret_valid = 1'b1;
        tick();
        ret_valid = 1'b0;
        total++;
        if (err !== 1'b1 || pix_valid !== 1'b1 || pix_addr !== 20'd0) begin
            bad++;
            $display("FAIL err_ret_underflow: got err=%b valid=%b addr=%0d want 1 1 0",
                     err, pix_valid, pix_addr);
        end
        pix_ready = 1'b1;
        repeat (3) tick();
        ret_valid = 1'b1;
        tick();
        ret_valid = 1'b0;
        total++;
        if (pix_valid !== 1'b1 || pix_addr !== 20'd4) begin
            bad++;
            $display("FAIL simul_xfer_ret: got valid=%b addr=%0d want 1 4", pix_valid, pix_addr);
        end
        tick();
        pix_ready = 1'b0;
        total++;
        if (pix_valid !== 1'b0 || n_xfer !== 5) begin
            bad++;
            $display("FAIL simul_count: got valid=%b xfers=%0d want 0 5", pix_valid, n_xfer);
        end
        repeat (3) tick();
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: got err=%b want 1", err);
        end
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        total++;
        if ({pix_valid, pix_x, pix_y, pix_addr, busy, frame_done, err} !== 30'd0) begin
            bad++;
            $display("FAIL midframe_reset: got %h want 0",
                     {pix_valid, pix_x, pix_y, pix_addr, busy, frame_done, err});
        end
        rst_n = 1'b1;
        tick();
        line_done = 1'b1;
        tick();
        line_done = 1'b0;
        tick();
        total++;
        if ({err, busy, pix_valid} !== 3'b100) begin
            bad++;
            $display("FAIL err_line_underflow: got err=%b busy=%b valid=%b want 1 0 0",
                     err, busy, pix_valid);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: got err=%b want 0", err);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        pix_ready   = 1'b0;
        ret_valid   = 1'b0;
        line_done   = 1'b0;
        test_reset();
        test_credit_limit();
        test_line_window();
        test_backpressure();
        test_frame_end();
        test_errors();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time exceeded, want finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pixel_dispatch.md
# pixel_dispatch

- Frame-level pixel request generator at the head of the render pipeline, in the `PPL_clk` domain.
- It walks the frame in raster order and issues one request per pixel, carrying `{x, y, linear address}`, to the pipeline.
- It keeps the pipeline's out-of-order return window within the reorder depth `N` of the downstream sort stage.
- It keeps the number of completed-but-unconsumed lines within what the downstream line FIFO (`H_DISP+64` deep) can hold.

## Interface

Parameters:
- `H_DISP`, 1280, active pixels per line
- `V_DISP`, 720, active lines per frame
- `N`, 16, max outstanding pixel requests; must match the downstream sort depth
- `LINES_AHEAD`, 1, max fully issued lines not yet acknowledged by `line_done`

Ports:
- `PPL_clk`  in  1  single clock. Reset is synchronous and active-low.
- `rst_n`  in  1  synchronous active-low reset
- `frame_start`  in  1  one-cycle pulse, already synchronised into `PPL_clk`
- `pix_ready`  in  1  pipeline accepts the current request
- `pix_valid`  out  1  request valid
- `pix_x`  out  `$clog2(H_DISP)`  pixel column
- `pix_y`  out  `$clog2(V_DISP)`  pixel row
- `pix_addr`  out  20  `y*H_DISP + x`
- `ret_valid`  in  1  one pixel result left the pipeline; returns one credit
- `line_done`  in  1  one-cycle pulse; downstream consumed one line
- `busy`  out  1  state is not IDLE
- `frame_done`  out  1  one-cycle pulse at end of frame
- `err`  out  1  sticky protocol error flag

## Operation

States:
- **IDLE**
  - `frame_start` → RUN.
  - On entry to RUN: x = y = addr = 0, outstanding = 0, lines_pending = 0.
- **RUN**
  - Transfer occurs when `pix_valid & pix_ready`.
  - After a transfer, x and addr increment. Addr is incremental, never multiplied.
  - At x = H_DISP-1: x ← 0, y ← y+1, lines_pending ← lines_pending+1 (net of a same-cycle `line_done`).
  - If the new lines_pending equals LINES_AHEAD → WAIT_LINE.
  - Transfer of the pixel at (H_DISP-1, V_DISP-1) → DRAIN.
- **WAIT_LINE**
  - `pix_valid` = 0.
  - When lines_pending < LINES_AHEAD → RUN.
- **DRAIN**
  - `pix_valid` = 0.
  - When outstanding == 0 and lines_pending == 0: `frame_done` pulse, → IDLE.

Counters:
- outstanding (0..N): +1 on transfer, −1 on `ret_valid`. Both in the same cycle → unchanged.
- lines_pending (0..LINES_AHEAD): +1 on line completion, −1 on `line_done`. Both in the same cycle → unchanged.

Issue rule:
- `pix_valid` is asserted in RUN only when outstanding_next < N.
- Once asserted, `pix_valid` and the payload stay constant until accepted.
- The only exception to the hold rule is reset.

Boundary conditions:
- `ret_valid` while outstanding == 0: ignored, `err` ← 1.
- `line_done` while lines_pending == 0: ignored, `err` ← 1.
- `frame_start` while not IDLE: ignored; no error is raised.
- `err` clears only on reset.
- Reset mid-frame: abort on that edge; all state and outputs return to their reset values.

## Timing

- All outputs are registered.
- Reset values: `pix_valid` = 0, `pix_x` = 0, `pix_y` = 0, `pix_addr` = 0, `busy` = 0, `frame_done` = 0, `err` = 0.
- `frame_start` sampled at edge t → `busy` = 1 and `pix_valid` = 1 from cycle t+1, with payload (0, 0, 0).
- Throughput is 1 pixel/cycle while `pix_ready` = 1, outstanding < N, and the line window is open.
- The N-th outstanding transfer at edge t → `pix_valid` = 0 at t+1. If `ret_valid` coincides at t, `pix_valid` stays 1.
- A credit or `line_done` at edge t → `pix_valid` may rise at t+1.
- `frame_done` is high for exactly 1 cycle. `busy` falls in the same cycle.
- IDLE re-accepts `frame_start` from the cycle after `frame_done`.

## Test plan

All scenarios use `H_DISP`=8, `V_DISP`=4, `N`=4, `LINES_AHEAD`=1.

1. Reset and start.
   - Stimulus: `rst_n` = 0 for 3 cycles, all inputs toggling.
   - Response: all outputs 0.
   - Then `frame_start` pulse at edge t → `pix_valid` = 1 at t+1, x=0, y=0, addr=0.
2. Credit limit.
   - Stimulus: `pix_ready` = 1, no `ret_valid`.
   - Response: exactly 4 transfers (addr 0..3), then `pix_valid` = 0 and held low.
   - One `ret_valid` → exactly one more transfer, addr 4.
3. Line window.
   - Stimulus: `ret_valid` returned for every transfer.
   - Response: after addr 7, `pix_valid` = 0 (WAIT_LINE).
   - `line_done` at t → `pix_valid` at t+1 with x=0, y=1, addr=8.
4. Backpressure.
   - Stimulus: random `pix_ready`, with credit and `line_done` returns.
   - Response: payload stable whenever `pix_valid & !pix_ready`.
   - Accepted addresses are 0..31 in order, with no gaps or duplicates.
5. Frame end.
   - Stimulus: complete the frame, returning all credits and 4 `line_done` pulses.
   - Response: a single `frame_done` pulse, `busy` = 0.
   - A `frame_start` pulsed during the frame was ignored.
   - A second `frame_start` restarts at addr 0.
6. Errors and simultaneity.
   - Stimulus: `ret_valid` with outstanding = 0.
   - Response: `err` = 1, and it stays 1 until `rst_n` = 0.
   - Stimulus: transfer and `ret_valid` in the same cycle at outstanding = 3.
   - Response: outstanding stays 3, `pix_valid` stays 1.
